// File: rtl/alu_mdu_unit.sv
`default_nettype none
// ============================================================================
// alu_mdu_unit : 1-cycle ALU, pipelined multiplier, iterative radix-2 divider
// Revision 1.0
// ============================================================================
module alu_mdu_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 6,
  parameter int MUL_STAGES = 3,
  parameter int SHAMT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [5:0]        ope,
  input  logic [XLEN-1:0]   ds_val,
  input  logic [XLEN-1:0]   dt_val,
  input  logic [ADDR_W-1:0] dd,
  input  logic [15:0]       imm,
  output logic [1:0]        is_busy,
  output logic [ADDR_W-1:0] alu_addr,
  output logic [XLEN-1:0]   alu_dd_val,
  output logic [ADDR_W-1:0] mdu_addr,
  output logic [XLEN-1:0]   mdu_dd_val
);

  localparam logic [5:0] c_op_lui  = 6'b110000;
  localparam logic [5:0] c_op_add  = 6'b001100;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_sub  = 6'b010100;
  localparam logic [5:0] c_op_sll  = 6'b011100;
  localparam logic [5:0] c_op_slli = 6'b011000;
  localparam logic [5:0] c_op_srl  = 6'b100100;
  localparam logic [5:0] c_op_srli = 6'b100000;
  localparam logic [5:0] c_op_sra  = 6'b101100;
  localparam logic [5:0] c_op_srai = 6'b101000;
  localparam logic [5:0] c_op_and  = 6'b110100;
  localparam logic [5:0] c_op_or   = 6'b111000;
  localparam logic [5:0] c_op_xor  = 6'b111100;
  localparam logic [5:0] c_op_mul  = 6'b000101;
  localparam logic [5:0] c_op_mulh = 6'b001101;
  localparam logic [5:0] c_op_div  = 6'b010101;
  localparam logic [5:0] c_op_rem  = 6'b011101;

  localparam logic [XLEN-1:0]    c_lo16_mask  = XLEN'(32'h0000_ffff);
  localparam logic [SHAMT_W-1:0] c_last_iter  = SHAMT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} div_state_e;

  // ---------------- ALU ----------------
  logic [XLEN-1:0]    w_imm_ext, w_opb, w_alu_res;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_alu_issue, w_alu_ok;
  logic [ADDR_W-1:0]  alu_addr_q, alu_addr_d;
  logic [XLEN-1:0]    alu_val_q, alu_val_d;

  assign w_imm_ext   = XLEN'($signed(imm));
  assign w_opb       = ope[2] ? dt_val : w_imm_ext;
  assign w_shamt     = w_opb[SHAMT_W-1:0];
  assign w_alu_issue = issue && (ope[1:0] == 2'b00) && (ope != 6'd0);

  always_comb begin
    w_alu_ok  = 1'b1;
    w_alu_res = '0;
    case (ope)
      c_op_lui:            w_alu_res = (w_imm_ext << 16) | (ds_val & c_lo16_mask);
      c_op_add, c_op_addi: w_alu_res = ds_val + w_opb;
      c_op_sub:            w_alu_res = ds_val - w_opb;
      c_op_sll, c_op_slli: w_alu_res = ds_val << w_shamt;
      c_op_srl, c_op_srli: w_alu_res = ds_val >> w_shamt;
      c_op_sra, c_op_srai: w_alu_res = $unsigned($signed(ds_val) >>> w_shamt);
      c_op_and:            w_alu_res = ds_val & w_opb;
      c_op_or:             w_alu_res = ds_val | w_opb;
      c_op_xor:            w_alu_res = ds_val ^ w_opb;
      default:             w_alu_ok  = 1'b0;
    endcase
    alu_addr_d = (w_alu_issue && w_alu_ok) ? dd : '0;
    alu_val_d  = w_alu_issue ? w_alu_res : alu_val_q;
  end

  // ---------------- MDU issue ----------------
  div_state_e state_q, state_d;
  logic w_mdu_ok, w_mul_issue, w_div_issue;

  // MDU ops arriving while the divider owns the unit are silently dropped.
  assign w_mdu_ok    = issue && (ope[1:0] == 2'b01) && (state_q == S_IDLE);
  assign w_mul_issue = w_mdu_ok && ((ope == c_op_mul) || (ope == c_op_mulh));
  assign w_div_issue = w_mdu_ok && ((ope == c_op_div) || (ope == c_op_rem));

  // ---------------- multiplier pipeline ----------------
  logic [2*XLEN-1:0]     w_prod;
  logic [MUL_STAGES-1:0] mul_vld_q, mul_vld_d;
  logic [ADDR_W-1:0]     mul_tag_q [MUL_STAGES];
  logic [ADDR_W-1:0]     mul_tag_d [MUL_STAGES];
  logic [XLEN-1:0]       mul_val_q [MUL_STAGES];
  logic [XLEN-1:0]       mul_val_d [MUL_STAGES];

  assign w_prod = $signed({{XLEN{ds_val[XLEN-1]}}, ds_val}) *
                  $signed({{XLEN{dt_val[XLEN-1]}}, dt_val});

  always_comb begin
    mul_vld_d[0] = w_mul_issue;
    mul_tag_d[0] = dd;
    mul_val_d[0] = ope[3] ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    for (int i = 1; i < MUL_STAGES; i++) begin
      mul_vld_d[i] = mul_vld_q[i-1];
      mul_tag_d[i] = mul_tag_q[i-1];
      mul_val_d[i] = mul_val_q[i-1];
    end
  end

  // ---------------- divider ----------------
  logic [XLEN-1:0]    quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, isrem_q, isrem_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  dtag_q, dtag_d;
  logic [XLEN:0]      w_rem_cat, w_trial;
  logic [XLEN-1:0]    w_div_res;

  assign w_rem_cat = {rem_q, quo_q[XLEN-1]};
  assign w_trial   = w_rem_cat - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    isrem_d = isrem_q;
    dtag_d  = dtag_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_div_issue) begin
          // Magnitudes as unsigned; the most-negative value maps to 2^(XLEN-1).
          quo_d   = ds_val[XLEN-1] ? -ds_val : ds_val;
          dvs_d   = dt_val[XLEN-1] ? -dt_val : dt_val;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = ds_val[XLEN-1] ^ dt_val[XLEN-1];
          rneg_d  = ds_val[XLEN-1];
          dz_d    = (dt_val == '0);
          isrem_d = ope[3];
          dtag_d  = dd;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (w_rem_cat >= {1'b0, dvs_q}) begin
          rem_d = w_trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = w_rem_cat[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == c_last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divide by zero leaves the dividend magnitude in rem, so only the quotient needs overriding.
  always_comb begin
    w_div_res = '0;
    if (isrem_q)   w_div_res = rneg_q ? -rem_q : rem_q;
    else if (dz_q) w_div_res = '1;
    else           w_div_res = qneg_q ? -quo_q : quo_q;
  end

  // ---------------- MDU writeback ----------------
  logic [XLEN-1:0] mdu_val_q, mdu_val_d;

  always_comb begin
    mdu_addr   = '0;
    mdu_dd_val = mdu_val_q;
    if (done_q) begin
      mdu_addr   = dtag_q;
      mdu_dd_val = w_div_res;
    end else if (mul_vld_q[MUL_STAGES-1]) begin
      mdu_addr   = mul_tag_q[MUL_STAGES-1];
      mdu_dd_val = mul_val_q[MUL_STAGES-1];
    end
    mdu_val_d = mdu_dd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_addr_q <= '0;
      alu_val_q  <= '0;
      mul_vld_q  <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_tag_q[i] <= '0;
        mul_val_q[i] <= '0;
      end
      state_q   <= S_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      isrem_q   <= 1'b0;
      dtag_q    <= '0;
      done_q    <= 1'b0;
      mdu_val_q <= '0;
    end else begin
      alu_addr_q <= alu_addr_d;
      alu_val_q  <= alu_val_d;
      mul_vld_q  <= mul_vld_d;
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_tag_q[i] <= mul_tag_d[i];
        mul_val_q[i] <= mul_val_d[i];
      end
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      isrem_q   <= isrem_d;
      dtag_q    <= dtag_d;
      done_q    <= done_d;
      mdu_val_q <= mdu_val_d;
    end
  end

  assign alu_addr   = alu_addr_q;
  assign alu_dd_val = alu_val_q;
  assign is_busy    = {|mul_vld_q, state_q != S_IDLE};

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_mdu_unit : directed self-checking bench for alu_mdu_unit
// Revision 1.0
// ============================================================================
module tb_alu_mdu_unit;

  localparam logic [5:0] c_op_lui  = 6'b110000;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_sub  = 6'b010100;
  localparam logic [5:0] c_op_sra  = 6'b101100;
  localparam logic [5:0] c_op_xor  = 6'b111100;
  localparam logic [5:0] c_op_bad  = 6'b000100;
  localparam logic [5:0] c_op_mul  = 6'b000101;
  localparam logic [5:0] c_op_mulh = 6'b001101;
  localparam logic [5:0] c_op_div  = 6'b010101;
  localparam logic [5:0] c_op_rem  = 6'b011101;

  logic        clk = 1'b0;
  logic        rst, issue;
  logic [5:0]  ope;
  logic [31:0] ds_val, dt_val;
  logic [5:0]  dd;
  logic [15:0] imm;
  logic [1:0]  is_busy;
  logic [5:0]  alu_addr, mdu_addr;
  logic [31:0] alu_dd_val, mdu_dd_val;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt, extra, lat;
  logic [31:0] got_val;
  logic [5:0]  got_tag;

  alu_mdu_unit #(.XLEN(32), .ADDR_W(6), .MUL_STAGES(3), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .ope        (ope),
    .ds_val     (ds_val),
    .dt_val     (dt_val),
    .dd         (dd),
    .imm        (imm),
    .is_busy    (is_busy),
    .alu_addr   (alu_addr),
    .alu_dd_val (alu_dd_val),
    .mdu_addr   (mdu_addr),
    .mdu_dd_val (mdu_dd_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] s, input logic [31:0] t,
                       input logic [5:0] d, input logic [15:0] im);
    issue = 1'b1; ope = op; ds_val = s; dt_val = t; dd = d; imm = im;
  endtask

  task automatic idle();
    issue = 1'b0; ope = '0; ds_val = '0; dt_val = '0; dd = '0; imm = '0;
  endtask

  task automatic alu_op(input string tag, input logic [5:0] op, input logic [31:0] s,
                        input logic [31:0] t, input logic [5:0] d, input logic [15:0] im,
                        input logic [5:0] exp_tag, input logic [31:0] exp_val);
    drive(op, s, t, d, im);
    tick();
    idle();
    check({tag, "_tag"}, alu_addr, exp_tag);
    check({tag, "_val"}, alu_dd_val, exp_val);
  endtask

  task automatic run_div(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] d, input logic [31:0] exp_val);
    drive(op, a, b, d, '0);
    tick();
    idle();
    lat = 0; got_tag = '0; got_val = '0;
    for (int k = 1; k <= 40; k++) begin
      if (mdu_addr != '0) begin
        lat = k; got_tag = mdu_addr; got_val = mdu_dd_val;
        break;
      end
      tick();
    end
    check({tag, "_latency"}, lat, 34);
    check({tag, "_tag"}, got_tag, d);
    check({tag, "_val"}, got_val, exp_val);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_alu_addr", alu_addr, 0);
    check("reset_alu_val", alu_dd_val, 0);
    check("reset_mdu_addr", mdu_addr, 0);
    check("reset_mdu_val", mdu_dd_val, 0);
    check("reset_busy", is_busy, 0);

    alu_op("addi", c_op_addi, 32'd5, 32'd0, 6'd7, 16'hFFFF, 6'd7, 32'd4);
    tick();
    check("alu_idle_tag", alu_addr, 0);
    check("alu_idle_hold", alu_dd_val, 32'd4);
    alu_op("sra", c_op_sra, 32'h8000_0000, 32'd4, 6'd8, 16'h0, 6'd8, 32'hF800_0000);
    alu_op("lui", c_op_lui, 32'hABCD_5678, 32'd0, 6'd9, 16'h1234, 6'd9, 32'h1234_5678);
    alu_op("sub_wrap", c_op_sub, 32'd3, 32'd5, 6'd3, 16'h0, 6'd3, 32'hFFFF_FFFE);
    alu_op("xor", c_op_xor, 32'hF0F0_1234, 32'h0FF0_FFFF, 6'd4, 16'h0, 6'd4, 32'hFF00_EDCB);
    alu_op("dd_zero", c_op_addi, 32'd1, 32'd0, 6'd0, 16'd2, 6'd0, 32'd3);
    alu_op("unlisted", c_op_bad, 32'd1, 32'd2, 6'd5, 16'd2, 6'd0, 32'd0);

    drive(c_op_mul, 32'd3, 32'd4, 6'd10, '0);
    tick();
    check("mul_busy_c1", is_busy, 2'b10);
    drive(c_op_mul, 32'hFFFF_FFFF, 32'd2, 6'd11, '0);
    tick();
    check("mul_early_tag", mdu_addr, 0);
    drive(c_op_mulh, 32'h8000_0000, 32'h8000_0000, 6'd12, '0);
    tick();
    idle();
    check("mul0_tag", mdu_addr, 6'd10);
    check("mul0_val", mdu_dd_val, 32'd12);
    tick();
    check("mul1_tag", mdu_addr, 6'd11);
    check("mul1_val", mdu_dd_val, 32'hFFFF_FFFE);
    check("mul1_busy", is_busy, 2'b10);
    tick();
    check("mulh_tag", mdu_addr, 6'd12);
    check("mulh_val", mdu_dd_val, 32'h4000_0000);
    check("mulh_busy", is_busy, 2'b10);
    tick();
    check("mul_drain_tag", mdu_addr, 0);
    check("mul_drain_hold", mdu_dd_val, 32'h4000_0000);
    check("mul_drain_busy", is_busy, 2'b00);

    drive(c_op_div, 32'hFFFF_FFF9, 32'd2, 6'd13, '0);
    tick();
    idle();
    busy_cnt = 0; extra = 0;
    for (int k = 1; k <= 34; k++) begin
      if (is_busy[0]) busy_cnt++;
      if (k < 34 && mdu_addr != '0) extra++;
      if (k == 7) begin
        check("alu_mid_div_tag", alu_addr, 6'd21);
        check("alu_mid_div_val", alu_dd_val, 32'd2);
      end
      if (k == 34) begin
        check("div_tag", mdu_addr, 6'd13);
        check("div_val", mdu_dd_val, 32'hFFFF_FFFD);
        check("div_busy_clear", is_busy, 2'b00);
      end
      if (k == 5)      drive(c_op_mul, 32'd6, 32'd7, 6'd20, '0);
      else if (k == 6) drive(c_op_addi, 32'd1, 32'd0, 6'd21, 16'd1);
      else             idle();
      tick();
    end
    check("div_busy_cycles", busy_cnt, 33);
    check("div_no_extra_wb", extra, 0);

    run_div("rem", c_op_rem, 32'hFFFF_FFF9, 32'd2, 6'd14, 32'hFFFF_FFFF);
    run_div("div_by0", c_op_div, 32'd9, 32'd0, 6'd15, 32'hFFFF_FFFF);
    run_div("rem_by0", c_op_rem, 32'd9, 32'd0, 6'd16, 32'd9);
    run_div("div_ovf", c_op_div, 32'h8000_0000, 32'hFFFF_FFFF, 6'd17, 32'h8000_0000);
    run_div("rem_ovf", c_op_rem, 32'h8000_0000, 32'hFFFF_FFFF, 6'd18, 32'd0);

    drive(c_op_div, 32'd100, 32'd7, 6'd22, '0);
    tick();
    idle();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_div_busy", is_busy, 2'b00);
    check("rst_mid_div_tag", mdu_addr, 0);
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdu_addr != '0) extra++;
      tick();
    end
    check("rst_mid_div_no_wb", extra, 0);
    run_div("div_after_rst", c_op_div, 32'd100, 32'd7, 6'd23, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
